axi4lite_regbank: RTL and testbench
===================================

AXI4LITE_REGBANK -- requirements
Module: axi4lite_regbank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width; only 32 is supported.
REQ-003 SHALL have parameter ID_VALUE, default 32'h534F_4301, constant returned by register 7.
REQ-004 SHALL have ports: clk in 1, system clock; rst_n in 1, reset, synchronous, active-low.
REQ-005 SHALL have ports: awvalid in 1; awready out 1; awaddr in ADDR_WIDTH; awprot in 3 (ignored).
REQ-006 SHALL have ports: wvalid in 1; wready out 1; wdata in 32; wstrb in 4.
REQ-007 SHALL have ports: bvalid out 1; bready in 1; bresp out 2.
REQ-008 SHALL have ports: arvalid in 1; arready out 1; araddr in ADDR_WIDTH; arprot in 3 (ignored).
REQ-009 SHALL have ports: rvalid out 1; rready in 1; rdata out 32; rresp out 2; rlast out 1.
REQ-010 SHALL have ports: status_i in 32, hardware status sampled for register 6; ctrl_o out 192, registers 0..5 concatenated, reg0 in bits [31:0].

Function
REQ-011 SHALL act as AXI4-Lite slave, one clock domain, all state updated on rising clk.
REQ-012 SHALL decode word index = addr[4:2]; addr[1:0] ignored; addr[ADDR_WIDTH-1:5] nonzero = out of range.
REQ-013 SHALL implement registers 0..5 as RW, 6 as RO (status_i), 7 as RO (ID_VALUE).
REQ-014 SHALL assert awready = !aw_held && !bvalid and wready = !w_held && !bvalid; AW and W channels accepted independently, in either order or same cycle.
REQ-015 SHALL commit a write at the edge where both AW and W are held or handshaking, setting bvalid=1 at that edge and clearing aw_held/w_held.
REQ-016 SHALL update RW register bytes only where wstrb bit set; wstrb=0 gives OKAY with no change.
REQ-017 SHALL respond bresp: 2'b00 OKAY for RW; 2'b10 SLVERR for write to reg 6/7 (no change); 2'b11 DECERR for out of range (no change).
REQ-018 SHALL hold bvalid and bresp stable until bready=1; clear bvalid at that edge; no new AW/W accepted while bvalid=1.
REQ-019 SHALL assert arready = !rvalid; one outstanding read.
REQ-020 SHALL on AR handshake capture rdata and rresp, set rvalid=1 next cycle (latency 1).
REQ-021 SHALL return rresp 2'b00 with register value in range, 2'b11 with rdata=0 out of range; reads of 6/7 are OKAY.
REQ-022 SHALL hold rvalid, rdata, rresp stable until rready=1; clear rvalid at that edge.
REQ-023 SHALL drive rlast=1 constantly.
REQ-024 SHALL return pre-write value when a read of register X handshakes at the same edge a write to X commits.
REQ-025 SHALL service read and write channels concurrently with no mutual stall.
REQ-026 SHALL drive ctrl_o directly from register flops (no combinational path from bus).

Reset
REQ-027 SHALL on rst_n=0 at a clk edge clear registers 0..5 to 0, aw_held, w_held, bvalid, rvalid to 0, bresp, rresp, rdata to 0.
REQ-028 SHALL drive awready=wready=arready=0 while rst_n=0, and 1 the first cycle after release.
REQ-029 SHALL drop any in-flight transaction on reset with no response issued afterward.

Verification
REQ-030 SHALL verify: AW+W same cycle addr 0x04 data 0xDEADBEEF strb 4'hF -> bvalid next cycle, bresp 00, ctrl_o[63:32]=0xDEADBEEF.
REQ-031 SHALL verify: W first (0x000000AA, strb 4'b0001) then AW 0x00 three cycles later -> reg0=0x000000AA, one B response only after AW.
REQ-032 SHALL verify: write 0x1C -> bresp 10, reg unchanged; read 0x1C -> rdata=ID_VALUE, rresp 00; read 0x40 -> rresp 11, rdata 0.
REQ-033 SHALL verify: bready held low 5 cycles -> bvalid, bresp stable, awready=wready=0 throughout; read meanwhile completes.
REQ-034 SHALL verify: status_i=0x12345678, read 0x18 -> rdata 0x12345678 one cycle after AR handshake.
REQ-035 SHALL verify: rst_n low for one cycle with aw_held=1 and rvalid=1 -> all valids 0, ctrl_o=0, no stale B or R afterward.

Source files
------------

// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave register bank: six RW control registers, one sampled status
// register and one constant ID register; read and write channels run independently.
module axi4lite_regbank #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'h534F_4301
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [2:0]                awprot,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [2:0]                arprot,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    input  logic [DATA_WIDTH-1:0]     status_i,
    output logic [6*DATA_WIDTH-1:0]   ctrl_o
);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    localparam int unsigned NUM_RW = 6;
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_regs [NUM_RW];
    logic                  r_aw_held;
    logic [2:0]            r_aw_idx;
    logic                  r_aw_oor;
    logic                  r_w_held;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NUM_BYTES-1:0]  r_wstrb;
    logic                  r_bvalid;
    resp_e                 r_bresp;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    resp_e                 r_rresp;

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_arready;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [2:0]            w_wr_idx;
    logic                  w_wr_oor;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [NUM_BYTES-1:0]  w_wr_strb;
    resp_e                 w_wr_resp;
    logic [2:0]            w_rd_idx;
    logic                  w_rd_oor;
    logic [DATA_WIDTH-1:0] w_rd_data;
    resp_e                 w_rd_resp;
    logic                  w_unused;

    // Readies are forced low while reset is asserted, not just after it.
    assign w_awready = rst_n && !r_aw_held && !r_bvalid;
    assign w_wready  = rst_n && !r_w_held && !r_bvalid;
    assign w_arready = rst_n && !r_rvalid;

    assign w_aw_hs  = awvalid && w_awready;
    assign w_w_hs   = wvalid && w_wready;
    assign w_ar_hs  = arvalid && w_arready;
    assign w_commit = !r_bvalid && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    // A channel handshaking in the commit cycle is used directly, bypassing its hold flop.
    assign w_wr_idx  = r_aw_held ? r_aw_idx : awaddr[4:2];
    assign w_wr_oor  = r_aw_held ? r_aw_oor : (awaddr[ADDR_WIDTH-1:5] != '0);
    assign w_wr_data = r_w_held ? r_wdata : wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : wstrb;

    assign w_rd_idx = araddr[4:2];
    assign w_rd_oor = (araddr[ADDR_WIDTH-1:5] != '0);

    assign w_unused = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

    always_comb begin
        w_wr_resp = RESP_OKAY;
        if (w_wr_oor) begin
            w_wr_resp = RESP_DECERR;
        end else if (w_wr_idx >= 3'(NUM_RW)) begin
            w_wr_resp = RESP_SLVERR;
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        if (w_rd_oor) begin
            w_rd_resp = RESP_DECERR;
        end else if (w_rd_idx == 3'd6) begin
            w_rd_data = status_i;
        end else if (w_rd_idx == 3'd7) begin
            w_rd_data = ID_VALUE;
        end else begin
            for (int unsigned i = 0; i < NUM_RW; i++) begin
                if (w_rd_idx == 3'(i)) begin
                    w_rd_data = r_regs[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_RW; i++) begin
                r_regs[i] <= '0;
            end
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_oor  <= 1'b0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= awaddr[4:2];
                r_aw_oor  <= (awaddr[ADDR_WIDTH-1:5] != '0);
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
            if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_resp;
                if (w_wr_resp == RESP_OKAY) begin
                    for (int unsigned i = 0; i < NUM_RW; i++) begin
                        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                            if (w_wr_idx == 3'(i) && w_wr_strb[b]) begin
                                r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
                            end
                        end
                    end
                end
            end

            if (r_rvalid && rready) begin
                r_rvalid <= 1'b0;
            end
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end
        end
    end

    always_comb begin
        ctrl_o = '0;
        for (int unsigned i = 0; i < NUM_RW; i++) begin
            ctrl_o[DATA_WIDTH*i +: DATA_WIDTH] = r_regs[i];
        end
    end

    assign awready = w_awready;
    assign wready  = w_wready;
    assign arready = w_arready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = 1'b1;

endmodule

// File: tb/tb_axi4lite_regbank.sv
// Directed bench for axi4lite_regbank: a transaction-level register model is
// compared against the DUT every cycle, plus literal checks on key scenarios.
module tb_axi4lite_regbank;

    localparam logic [31:0] ID = 32'h534F_4301;

    logic         clk;
    logic         rst_n;
    logic         awvalid, awready;
    logic [31:0]  awaddr;
    logic [2:0]   awprot;
    logic         wvalid, wready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         bvalid, bready;
    logic [1:0]   bresp;
    logic         arvalid, arready;
    logic [31:0]  araddr;
    logic [2:0]   arprot;
    logic         rvalid, rready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic [31:0]  status_i;
    logic [191:0] ctrl_o;

    int total = 0;
    int bad   = 0;
    logic cmp_en = 1'b0;

    axi4lite_regbank #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .ID_VALUE  (ID)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arprot  (arprot),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .status_i(status_i),
        .ctrl_o  (ctrl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: pending AW/W, one outstanding B and R, register array.
    logic [31:0] m_regs [6];
    logic        m_aw_pend, m_w_pend, m_b_pend, m_r_pend;
    logic [31:0] m_aw_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    function automatic logic [33:0] read_word(input logic [31:0] a);
        int idx;
        if (a >= 32) return {2'b11, 32'h0};
        idx = int'(a / 4);
        if (idx == 6) return {2'b00, status_i};
        if (idx == 7) return {2'b00, ID};
        return {2'b00, m_regs[idx]};
    endfunction

    function automatic logic [191:0] model_ctrl();
        return {m_regs[5], m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    always @(posedge clk) begin : model
        automatic logic        aw_acc;
        automatic logic        w_acc;
        automatic logic [31:0] a;
        automatic logic [31:0] d;
        automatic logic [31:0] nv;
        automatic logic [3:0]  s;
        automatic int          idx;
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) m_regs[i] <= '0;
            m_aw_pend <= 1'b0;
            m_w_pend  <= 1'b0;
            m_b_pend  <= 1'b0;
            m_r_pend  <= 1'b0;
            m_aw_addr <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            m_bresp   <= '0;
            m_rresp   <= '0;
            m_rdata   <= '0;
        end else begin
            aw_acc = awvalid && !m_aw_pend && !m_b_pend;
            w_acc  = wvalid && !m_w_pend && !m_b_pend;
            if (m_r_pend && rready) m_r_pend <= 1'b0;
            if (arvalid && !m_r_pend) begin
                m_r_pend <= 1'b1;
                {m_rresp, m_rdata} <= read_word(araddr);
            end
            if (m_b_pend && bready) m_b_pend <= 1'b0;
            if (aw_acc) begin
                m_aw_pend <= 1'b1;
                m_aw_addr <= awaddr;
            end
            if (w_acc) begin
                m_w_pend <= 1'b1;
                m_wdata  <= wdata;
                m_wstrb  <= wstrb;
            end
            if ((m_aw_pend || aw_acc) && (m_w_pend || w_acc)) begin
                a = m_aw_pend ? m_aw_addr : awaddr;
                d = m_w_pend ? m_wdata : wdata;
                s = m_w_pend ? m_wstrb : wstrb;
                m_aw_pend <= 1'b0;
                m_w_pend  <= 1'b0;
                m_b_pend  <= 1'b1;
                if (a >= 32) begin
                    m_bresp <= 2'b11;
                end else if (a / 4 >= 6) begin
                    m_bresp <= 2'b10;
                end else begin
                    m_bresp <= 2'b00;
                    idx = int'(a / 4);
                    nv = m_regs[idx];
                    for (int b = 0; b < 4; b++) if (s[b]) nv[8*b +: 8] = d[8*b +: 8];
                    m_regs[idx] <= nv;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("awready", awready, rst_n && !m_aw_pend && !m_b_pend);
            check("wready", wready, rst_n && !m_w_pend && !m_b_pend);
            check("arready", arready, rst_n && !m_r_pend);
            check("bvalid", bvalid, m_b_pend);
            if (m_b_pend) check("bresp", bresp, m_bresp);
            check("rvalid", rvalid, m_r_pend);
            if (m_r_pend) begin
                check("rdata", rdata, m_rdata);
                check("rresp", rresp, m_rresp);
            end
            check("rlast", rlast, 1'b1);
            check("ctrl_o", ctrl_o, model_ctrl());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        awvalid = 1'b1; awaddr = a;
        wvalid  = 1'b1; wdata  = d; wstrb = s;
        cyc();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        arvalid = 1'b1; araddr = a;
        cyc();
        arvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        awvalid = 1'b0; awaddr = '0; awprot = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        arvalid = 1'b0; araddr = '0; arprot = '0;
        bready = 1'b1; rready = 1'b1;
        status_i = '0;
        cyc();
        cyc();
        check("rst_awready", awready, 1'b0);
        check("rst_arready", arready, 1'b0);
        rst_n = 1'b1;
        #1;
        check("post_rst_awready", awready, 1'b1);
        check("post_rst_wready", wready, 1'b1);
        check("post_rst_ctrl", ctrl_o, 192'h0);
        cmp_en = 1'b1;

        // AW and W together
        wr(32'h04, 32'hDEADBEEF, 4'hF);
        check("t1_bvalid", bvalid, 1'b1);
        check("t1_bresp", bresp, 2'b00);
        check("t1_reg1", ctrl_o[63:32], 32'hDEADBEEF);
        cyc();

        // W three cycles ahead of AW
        wvalid = 1'b1; wdata = 32'h0000_00AA; wstrb = 4'b0001;
        cyc();
        wvalid = 1'b0;
        check("t2_wready_held", wready, 1'b0);
        check("t2_no_b_0", bvalid, 1'b0);
        cyc();
        check("t2_no_b_1", bvalid, 1'b0);
        cyc();
        check("t2_no_b_2", bvalid, 1'b0);
        awvalid = 1'b1; awaddr = 32'h00;
        cyc();
        awvalid = 1'b0;
        check("t2_bvalid", bvalid, 1'b1);
        check("t2_reg0", ctrl_o[31:0], 32'h0000_00AA);
        cyc();
        check("t2_single_b", bvalid, 1'b0);

        // byte strobes and empty strobe
        wr(32'h04, 32'h0000_0000, 4'b0110);
        check("strb_reg1", ctrl_o[63:32], 32'hDE00_00EF);
        cyc();
        wr(32'h05, 32'hFFFF_FFFF, 4'b0000);
        check("strb0_bresp", bresp, 2'b00);
        check("strb0_reg1", ctrl_o[63:32], 32'hDE00_00EF);
        cyc();

        // RO / out-of-range accesses
        wr(32'h1C, 32'hFFFF_FFFF, 4'hF);
        check("ro_bresp", bresp, 2'b10);
        cyc();
        wr(32'h40, 32'hFFFF_FFFF, 4'hF);
        check("oor_bresp", bresp, 2'b11);
        cyc();
        rd(32'h1C);
        check("id_rvalid", rvalid, 1'b1);
        check("id_rdata", rdata, ID);
        check("id_rresp", rresp, 2'b00);
        cyc();
        rd(32'h40);
        check("oor_rresp", rresp, 2'b11);
        check("oor_rdata", rdata, 32'h0);
        cyc();

        // B backpressure with a concurrent read and a queued write
        wr(32'h08, 32'h1122_3344, 4'hF);
        bready = 1'b0;
        awvalid = 1'b1; awaddr = 32'h0C;
        wvalid = 1'b1; wdata = 32'h0000_0055; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h08;
        cyc();
        arvalid = 1'b0;
        check("bp_rvalid", rvalid, 1'b1);
        check("bp_rdata", rdata, 32'h1122_3344);
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", bvalid, 1'b1);
            check("bp_bresp", bresp, 2'b00);
            check("bp_awready", awready, 1'b0);
            check("bp_wready", wready, 1'b0);
            cyc();
        end
        bready = 1'b1;
        cyc();
        cyc();
        awvalid = 1'b0;
        wvalid = 1'b0;
        check("bp_next_b", bvalid, 1'b1);
        check("bp_reg3", ctrl_o[127:96], 32'h0000_0055);
        cyc();

        // status register read
        status_i = 32'h1234_5678;
        rd(32'h18);
        check("status_rdata", rdata, 32'h1234_5678);
        check("status_rresp", rresp, 2'b00);
        cyc();

        // read of a register in the same edge its write commits
        awvalid = 1'b1; awaddr = 32'h10;
        wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h10;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rw_same_rdata", rdata, 32'h0);
        check("rw_same_reg4", ctrl_o[159:128], 32'hCAFE_F00D);
        cyc();

        // reset with a held AW and a pending R
        rready = 1'b0;
        awvalid = 1'b1; awaddr = 32'h10;
        arvalid = 1'b1; araddr = 32'h00;
        cyc();
        awvalid = 1'b0; arvalid = 1'b0;
        check("pre_rst_rvalid", rvalid, 1'b1);
        check("pre_rst_awready", awready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("in_rst_arready", arready, 1'b0);
        check("in_rst_wready", wready, 1'b0);
        cyc();
        rst_n = 1'b1;
        rready = 1'b1;
        #1;
        check("rst2_bvalid", bvalid, 1'b0);
        check("rst2_rvalid", rvalid, 1'b0);
        check("rst2_ctrl", ctrl_o, 192'h0);
        check("rst2_awready", awready, 1'b1);
        wvalid = 1'b1; wdata = 32'h0000_0099; wstrb = 4'hF;
        cyc();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst2_no_stale_b", bvalid, 1'b0);
            check("rst2_no_stale_r", rvalid, 1'b0);
            cyc();
        end
        check("rst2_ctrl_end", ctrl_o, 192'h0);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
